round_ctrl: RTL and testbench
=============================

Name: round_ctrl

Overview:
Game-round controller sitting between the raw stop button, the wheel and the display path.
- Synchronises and debounces the stop button, then drives the wheel's stop level.
- Once the wheel has halted, it judges the player's guess against the final position and keeps score and round count.
- Produces the decimal-point blink pattern consumed by the 7-seg output mux.

Parameters:
DEBOUNCE_TICKS, 4, consecutive tick_i periods the synced button must differ from the debounced level before that level flips (1..15)
ROUNDS, 10, rounds per game before GAME_OVER (1..15)
BLINK_TICKS, 8, tick_i periods the result is shown in SHOW (1..255)
SCORE_W, 4, width of score counter

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
tick_i  in  1  one-cycle prescaler tick; the debounce and blink time base
stop_btn_i  in  1  raw asynchronous stop button, active high
running_i  in  1  wheel running flag
pos_i  in  3  wheel position, legal values 0..5
guess_i  in  6  one-hot guess from the player, bit n = position n
stop_o  out  1  stop level to the wheel
hit_o  out  1  last round result; valid from result_valid_o until the next result
result_valid_o  out  1  one-cycle pulse when hit_o and score_o update
score_o  out  SCORE_W  hits this game, saturating
round_o  out  4  completed rounds this game
game_over_o  out  1  high in GAME_OVER
dp_o  out  1  decimal-point drive

Behaviour:
Reset (async, rst_ni low):
- State is IDLE.
- All outputs are 0, the debounced level is 0, and all counters are 0.
- Reset mid-round abandons the round; no result pulse is produced.

Button synchroniser and debouncer:
- stop_btn_i passes through a 2-flop synchroniser.
- The debounce counter increments on tick_i while the synced value differs from the debounced level.
- The counter clears to 0 whenever the synced value equals the debounced level.
- On reaching DEBOUNCE_TICKS, the debounced level flips and the counter clears.
- A one-cycle press pulse fires on the rising edge of the debounced level.
- Latency from a clean button edge to the flip is 2 clk plus DEBOUNCE_TICKS ticks.

FSM:
- IDLE: stop_o=0. On press go to STOPPING.
- STOPPING: stop_o=1. When running_i is sampled 0, go to EVAL. If running_i is already 0 on entry, EVAL follows on the next cycle.
- EVAL (exactly one cycle): stop_o=1.
  - hit = (pos_i<=5) AND guess_i[pos_i] AND popcount(guess_i)==1. A zero or multi-hot guess is a miss.
  - Register hit_o and pulse result_valid_o.
  - score_o += hit, saturating at 2^SCORE_W-1.
  - round_o += 1.
  - Load the blink counter with BLINK_TICKS, then go to SHOW.
- SHOW: stop_o=1.
  - Each tick_i decrements the blink counter.
  - hit: dp_o toggles on every tick_i, starting at 1 on SHOW entry. miss: dp_o=0.
  - When the counter reaches 0: go to GAME_OVER if round_o==ROUNDS, else go to RELEASE.
- RELEASE: stop_o=1 and dp_o=0. When the debounced level is 0, go to IDLE, where stop_o drops and the wheel restarts.
- GAME_OVER: stop_o=1, dp_o=1, game_over_o=1.
  - On press: clear score_o and round_o, clear hit_o, and go to RELEASE.

Simultaneous events and boundaries:
- A press outside IDLE and GAME_OVER is ignored.
- tick_i in the same cycle as a state transition is consumed by the new state only if that state uses ticks (SHOW entry cycle does not decrement).
- Score saturation does not affect round counting.
- round_o never exceeds ROUNDS.

Decomposition:
Shared package (game_pkg):
- state encoding enum (IDLE, STOPPING, EVAL, SHOW, RELEASE, GAME_OVER)
- NUM_POS=6
- default ROUNDS / DEBOUNCE_TICKS constants

One sub-module, btn_debounce, holds the synchroniser, debounce counter and press pulse (params DEBOUNCE_TICKS; ports clk_i, rst_ni, tick_i, btn_i, level_o, press_o).

Test Plan:
- Reset mid-SHOW -> all outputs 0, state IDLE; the next press still needs the full DEBOUNCE_TICKS.
- Button bouncing (toggles shorter than 4 ticks) then held 4 ticks, DEBOUNCE_TICKS=4 -> exactly one press; stop_o rises 2 clk + 4 ticks after the stable edge.
- Hit round: press, running_i falls with pos_i=3, guess_i=6'b001000 -> one result_valid_o pulse, hit_o=1, score_o=1, round_o=1; dp_o toggles 8 times over 8 ticks.
- Miss cases: guess 6'b001100 with pos 2, guess 0, and pos_i=7 -> hit_o=0, score unchanged, dp_o=0 throughout SHOW.
- Full game, ROUNDS=3, all hits -> after the third SHOW, game_over_o=1, dp_o=1, stop_o=1. Press -> score/round cleared; after release -> IDLE, stop_o=0.
- Saturation, SCORE_W=2, ROUNDS=5, all hits -> score_o sticks at 3 while round_o reaches 5.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game-round controller: state encoding,
// wheel geometry, default timing constants and the guess judge.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STOPPING  = 3'd1,
    ST_EVAL      = 3'd2,
    ST_SHOW      = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam int NUM_POS            = 6;
  localparam int DEF_ROUNDS         = 10;
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_BLINK_TICKS    = 8;
  localparam int DEF_SCORE_W        = 4;

  // A guess wins only when it is exactly the one-hot code of a legal
  // position; zero, multi-hot and out-of-range positions all lose.
  function automatic logic is_hit(input logic [2:0] pos,
                                  input logic [NUM_POS-1:0] guess);
    logic [NUM_POS-1:0] mask;
    mask = {{(NUM_POS-1){1'b0}}, 1'b1} << pos;
    return (pos < 3'(NUM_POS)) && (guess == mask);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Stop-button front end: 2-flop synchroniser, tick-based debounce counter
// and a single-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic [3:0] cnt_q;
  logic       flip;

  // This tick completes the run of differing ticks, so the level flips at
  // the coming edge; press is flagged in the same cycle so the FSM sees it
  // on the very edge the level rises.
  assign flip    = tick_i && (sync2_q != level_q) &&
                   (cnt_q == 4'(DEBOUNCE_TICKS - 1));
  assign press_o = flip && !level_q;
  assign level_o = level_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count ticks while the synced input disagrees with the level; any
  // agreement restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
    end else if (sync2_q == level_q) begin
      cnt_q <= 4'd0;
    end else if (flip) begin
      level_q <= ~level_q;
      cnt_q   <= 4'd0;
    end else if (tick_i) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Game-round controller: stops the wheel on a debounced press, judges the
// guess once the wheel halts, keeps score/round count and drives the
// decimal-point blink pattern. state_o exposes the FSM for observation.
module round_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int ROUNDS         = DEF_ROUNDS,
  parameter int BLINK_TICKS    = DEF_BLINK_TICKS,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               stop_btn_i,
  input  logic               running_i,
  input  logic [2:0]         pos_i,
  input  logic [NUM_POS-1:0] guess_i,
  output logic               stop_o,
  output logic               hit_o,
  output logic               result_valid_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [3:0]         round_o,
  output logic               game_over_o,
  output logic               dp_o,
  output logic [2:0]         state_o
);

  // Result interface: result_valid_o is a one-cycle strobe with no ready;
  // in that cycle hit_o, score_o and round_o carry the freshly judged round
  // and they hold until the next strobe (or the game-over clear).

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q, state_d;
  logic               level;
  logic               press;
  logic               hit_q;
  logic               valid_q;
  logic [SCORE_W-1:0] score_q;
  logic [3:0]         round_q;
  logic [7:0]         blink_q;
  logic               dp_q;
  logic               last_round;
  logic               blink_done;

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_i (tick_i),
    .btn_i  (stop_btn_i),
    .level_o(level),
    .press_o(press)
  );

  assign last_round = (round_q == 4'(ROUNDS));
  assign blink_done = tick_i && (blink_q == 8'd1);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and state-dependent outputs.
  always_comb begin
    state_d     = state_q;
    stop_o      = 1'b1;
    dp_o        = 1'b0;
    game_over_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_o = 1'b0;
        if (press) state_d = ST_STOPPING;
      end
      ST_STOPPING: if (!running_i) state_d = ST_EVAL;
      ST_EVAL:     state_d = ST_SHOW;
      ST_SHOW: begin
        dp_o = hit_q & dp_q;
        if (blink_done) state_d = last_round ? ST_GAME_OVER : ST_RELEASE;
      end
      ST_RELEASE:  if (!level) state_d = ST_IDLE;
      ST_GAME_OVER: begin
        dp_o        = 1'b1;
        game_over_o = 1'b1;
        if (press) state_d = ST_RELEASE;
      end
      default: begin
        stop_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Round result, score/round counters and blink timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      score_q <= '0;
      round_q <= 4'd0;
      blink_q <= 8'd0;
      dp_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_EVAL: begin
          hit_q   <= is_hit(pos_i, guess_i);
          valid_q <= 1'b1;
          if (is_hit(pos_i, guess_i) && (score_q != SCORE_MAX))
            score_q <= score_q + 1'b1;
          if (!last_round) round_q <= round_q + 4'd1;
          blink_q <= 8'(BLINK_TICKS);
          dp_q    <= 1'b1;
        end
        ST_SHOW: begin
          if (tick_i) begin
            blink_q <= blink_q - 8'd1;
            dp_q    <= ~dp_q;
          end
        end
        ST_GAME_OVER: begin
          if (press) begin
            hit_q   <= 1'b0;
            score_q <= '0;
            round_q <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_o          = hit_q;
  assign result_valid_o = valid_q;
  assign score_o        = score_q;
  assign round_o        = round_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with DEBOUNCE_TICKS=4, ROUNDS=5,
// BLINK_TICKS=8, SCORE_W=2; ticks are driven explicitly by the tasks.
module tb_round_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_STOPPING = 3'd1, S_EVAL = 3'd2,
                         S_SHOW = 3'd3, S_RELEASE = 3'd4, S_GAME_OVER = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       running = 1'b1;
  logic [2:0] pos = 3'd0;
  logic [5:0] guess = 6'd0;
  logic       stop, hit, result_valid, game_over, dp;
  logic [1:0] score;
  logic [3:0] round_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  round_ctrl #(
    .DEBOUNCE_TICKS(4),
    .ROUNDS        (5),
    .BLINK_TICKS   (8),
    .SCORE_W       (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .stop_btn_i    (btn),
    .running_i     (running),
    .pos_i         (pos),
    .guess_i       (guess),
    .stop_o        (stop),
    .hit_o         (hit),
    .result_valid_o(result_valid),
    .score_o       (score),
    .round_o       (round_cnt),
    .game_over_o   (game_over),
    .dp_o          (dp),
    .state_o       (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Press from a released level: 2 sync clocks then 4 back-to-back ticks.
  task automatic press_button();
    btn = 1'b1;
    step();
    step();
    tick = 1'b1;
    repeat (4) step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({stop, hit, result_valid, score, round_cnt, game_over, dp, state} !== 14'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {stop, hit, result_valid, score, round_cnt, game_over, dp, state});
    end
    step();
    rst_n = 1'b1;
    step();
    // Reset in the middle of SHOW with the button still held.
    press_button();
    running = 1'b0; pos = 3'd1; guess = 6'b000010;
    step();
    step();
    n_checks++;
    if (state !== S_SHOW) begin
      n_fails++;
      $display("FAIL reset_reach_show: got %0d expected %0d", state, S_SHOW);
    end
    tick = 1'b1; step(); tick = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stop, hit, result_valid, score, round_cnt, game_over, dp, state} !== 14'd0) begin
      n_fails++;
      $display("FAIL reset_mid_show: got %b expected all zero",
               {stop, hit, result_valid, score, round_cnt, game_over, dp, state});
    end
    step();
    rst_n = 1'b1;
    running = 1'b1;
    step();
    step();
    for (int i = 1; i <= 4; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_checks++;
      if (stop !== (i == 4)) begin
        n_fails++;
        $display("FAIL reset_full_debounce tick %0d: got %b expected %b", i, stop, i == 4);
      end
      step();
    end
    btn = 1'b0;
    apply_reset();
  endtask

  task automatic test_debounce();
    // Bounce 1: high for 2 ticks.
    btn = 1'b1; step(); step();
    tick = 1'b1; repeat (2) step(); tick = 1'b0;
    btn = 1'b0; repeat (3) step();
    n_checks++;
    if (stop !== 1'b0) begin
      n_fails++;
      $display("FAIL bounce_1: got %b expected 0", stop);
    end
    // Bounce 2: high for 3 ticks.
    btn = 1'b1; repeat (3) step();
    tick = 1'b1; repeat (3) step(); tick = 1'b0;
    btn = 1'b0; repeat (3) step();
    n_checks++;
    if (stop !== 1'b0) begin
      n_fails++;
      $display("FAIL bounce_2: got %b expected 0", stop);
    end
    // Stable press, ticks spaced out by idle cycles.
    btn = 1'b1; step(); step();
    for (int i = 1; i <= 4; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n_checks++;
      if (stop !== (i == 4)) begin
        n_fails++;
        $display("FAIL debounce_latency tick %0d: got %b expected %b", i, stop, i == 4);
      end
      step();
    end
    // Holding the button produces no further press.
    tick = 1'b1; repeat (6) step(); tick = 1'b0;
    n_checks++;
    if (state !== S_STOPPING) begin
      n_fails++;
      $display("FAIL single_press: got %0d expected %0d", state, S_STOPPING);
    end
    btn = 1'b0;
    apply_reset();
  endtask

  task automatic play_round(input logic [2:0] p, input logic [5:0] g,
                            input logic exp_hit, input logic [1:0] exp_score,
                            input logic [3:0] exp_round, input logic exp_go);
    logic exp_dp;
    press_button();
    n_checks++;
    if (state !== S_STOPPING || stop !== 1'b1) begin
      n_fails++;
      $display("FAIL round%0d_stopping: got state %0d stop %b expected %0d 1",
               exp_round, state, stop, S_STOPPING);
    end
    running = 1'b0; pos = p; guess = g;
    step();
    n_checks++;
    if (state !== S_EVAL || result_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL round%0d_eval: got state %0d valid %b expected %0d 0",
               exp_round, state, result_valid, S_EVAL);
    end
    step();
    n_checks++;
    if ({state, result_valid, hit, score, round_cnt, dp} !==
        {S_SHOW, 1'b1, exp_hit, exp_score, exp_round, exp_hit}) begin
      n_fails++;
      $display("FAIL round%0d_result: got st %0d v %b hit %b sc %0d rd %0d dp %b expected %0d 1 %b %0d %0d %b",
               exp_round, state, result_valid, hit, score, round_cnt, dp,
               S_SHOW, exp_hit, exp_score, exp_round, exp_hit);
    end
    running = 1'b1; btn = 1'b0;
    step();
    n_checks++;
    if (result_valid !== 1'b0 || dp !== exp_hit) begin
      n_fails++;
      $display("FAIL round%0d_pulse_width: got valid %b dp %b expected 0 %b",
               exp_round, result_valid, dp, exp_hit);
    end
    exp_dp = exp_hit;
    for (int k = 1; k <= 7; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (exp_hit) exp_dp = ~exp_dp;
      n_checks++;
      if (dp !== exp_dp || state !== S_SHOW) begin
        n_fails++;
        $display("FAIL round%0d_blink tick %0d: got dp %b state %0d expected %b %0d",
                 exp_round, k, dp, state, exp_dp, S_SHOW);
      end
      step();
    end
    tick = 1'b1; step(); tick = 1'b0;
    if (exp_go) begin
      n_checks++;
      if ({state, game_over, dp, stop} !== {S_GAME_OVER, 3'b111}) begin
        n_fails++;
        $display("FAIL round%0d_game_over: got st %0d go %b dp %b stop %b expected %0d 1 1 1",
                 exp_round, state, game_over, dp, stop, S_GAME_OVER);
      end
    end else begin
      n_checks++;
      if (state !== S_RELEASE || dp !== 1'b0 || stop !== 1'b1) begin
        n_fails++;
        $display("FAIL round%0d_release: got st %0d dp %b stop %b expected %0d 0 1",
                 exp_round, state, dp, stop, S_RELEASE);
      end
      step();
      n_checks++;
      if (state !== S_IDLE || stop !== 1'b0) begin
        n_fails++;
        $display("FAIL round%0d_idle: got st %0d stop %b expected %0d 0",
                 exp_round, state, stop, S_IDLE);
      end
    end
  endtask

  task automatic test_hit_round();
    play_round(3'd3, 6'b001000, 1'b1, 2'd1, 4'd1, 1'b0);
  endtask

  task automatic test_miss_rounds();
    play_round(3'd2, 6'b001100, 1'b0, 2'd1, 4'd2, 1'b0);
    play_round(3'd5, 6'b000000, 1'b0, 2'd1, 4'd3, 1'b0);
    play_round(3'd7, 6'b000000, 1'b0, 2'd1, 4'd4, 1'b0);
  endtask

  task automatic test_game_over();
    play_round(3'd0, 6'b000001, 1'b1, 2'd2, 4'd5, 1'b1);
    press_button();
    n_checks++;
    if ({state, score, round_cnt, hit, stop, game_over} !== {S_RELEASE, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fails++;
      $display("FAIL game_over_clear: got st %0d sc %0d rd %0d hit %b stop %b go %b expected %0d 0 0 0 1 0",
               state, score, round_cnt, hit, stop, game_over, S_RELEASE);
    end
    btn = 1'b0; step(); step();
    tick = 1'b1; repeat (4) step(); tick = 1'b0;
    n_checks++;
    if (state !== S_RELEASE) begin
      n_fails++;
      $display("FAIL game_over_hold_release: got %0d expected %0d", state, S_RELEASE);
    end
    step();
    n_checks++;
    if (state !== S_IDLE || stop !== 1'b0) begin
      n_fails++;
      $display("FAIL game_over_to_idle: got st %0d stop %b expected %0d 0", state, stop, S_IDLE);
    end
  endtask

  task automatic test_saturation();
    play_round(3'd0, 6'b000001, 1'b1, 2'd1, 4'd1, 1'b0);
    play_round(3'd1, 6'b000010, 1'b1, 2'd2, 4'd2, 1'b0);
    play_round(3'd2, 6'b000100, 1'b1, 2'd3, 4'd3, 1'b0);
    play_round(3'd4, 6'b010000, 1'b1, 2'd3, 4'd4, 1'b0);
    play_round(3'd5, 6'b100000, 1'b1, 2'd3, 4'd5, 1'b1);
    tick = 1'b1; repeat (3) step(); tick = 1'b0;
    n_checks++;
    if (round_cnt !== 4'd5 || score !== 2'd3 || state !== S_GAME_OVER) begin
      n_fails++;
      $display("FAIL saturation_hold: got rd %0d sc %0d st %0d expected 5 3 %0d",
               round_cnt, score, state, S_GAME_OVER);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_hit_round();
    test_miss_rounds();
    test_game_over();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
